// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: cache miss fill controller.
// On a miss, stalls the pipeline, streams one aligned block of BLOCK_WORDS words
// from main memory into the cache data array, then writes the block tag.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   miss_detected, miss_address  miss request from the cache lookup
//   memory_data_valid/_data      word returned by memory (in request order)
//   fsm_busy                     pipeline stall (combinational)
//   mem_req, memory_address      one read request per cycle during a fill
//   write_data_array, data_array_addr, data_array_wdata   data array write port
//   write_tag_array, tag_array_addr                       tag array write port
// Optional feature macro CACHE_FILL_PERF_EN adds the saturating counters
// perf_miss_cnt and perf_stall_cnt.
module cache_fill_fsm #(
  parameter int unsigned AWIDTH      = 16,
  parameter int unsigned DWIDTH      = 16,
  parameter int unsigned BLOCK_WORDS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [AWIDTH-1:0] miss_address,
  input  logic              memory_data_valid,
  input  logic [DWIDTH-1:0] memory_data,
  output logic              fsm_busy,
  output logic              mem_req,
  output logic [AWIDTH-1:0] memory_address,
  output logic              write_data_array,
  output logic [AWIDTH-1:0] data_array_addr,
  output logic [DWIDTH-1:0] data_array_wdata,
  output logic              write_tag_array,
  output logic [AWIDTH-1:0] tag_array_addr
`ifdef CACHE_FILL_PERF_EN
  ,
  output logic [15:0]       perf_miss_cnt,
  output logic [15:0]       perf_stall_cnt
`endif
);

  localparam int unsigned RECV_W = $clog2(BLOCK_WORDS);
  localparam int unsigned ISS_W  = RECV_W + 1;
  localparam logic [ISS_W-1:0]  ISS_DONE  = ISS_W'(BLOCK_WORDS);
  localparam logic [RECV_W-1:0] RECV_LAST = RECV_W'(BLOCK_WORDS - 1);
  // Clears the byte offset within a block (2 bytes per word).
  localparam logic [AWIDTH-1:0] BASE_MASK = ~AWIDTH'(2 * BLOCK_WORDS - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t              r_state, w_state_nxt;
  logic [AWIDTH-1:0]   r_base, w_base_nxt;
  logic [ISS_W-1:0]    r_issue_cnt, w_issue_nxt;
  logic [RECV_W-1:0]   r_recv_cnt, w_recv_nxt;
  logic [AWIDTH-1:0]   w_issue_off, w_recv_off;

  // Word index to byte offset; base is aligned so the add never carries out of the block.
  assign w_issue_off = AWIDTH'(r_issue_cnt) << 1;
  assign w_recv_off  = AWIDTH'(r_recv_cnt) << 1;

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_base      <= '0;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_base      <= w_base_nxt;
      r_issue_cnt <= w_issue_nxt;
      r_recv_cnt  <= w_recv_nxt;
    end
  end

  // Next state and outputs. Memory/array outputs depend only on registered
  // state plus the memory return inputs, never on miss_detected.
  always_comb begin
    w_state_nxt      = r_state;
    w_base_nxt       = r_base;
    w_issue_nxt      = r_issue_cnt;
    w_recv_nxt       = r_recv_cnt;
    fsm_busy         = 1'b0;
    mem_req          = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    data_array_addr  = '0;
    data_array_wdata = '0;
    write_tag_array  = 1'b0;
    tag_array_addr   = '0;
    case (r_state)
      IDLE: begin
        if (miss_detected) begin
          fsm_busy    = 1'b1;
          w_base_nxt  = miss_address & BASE_MASK;
          w_issue_nxt = '0;
          w_recv_nxt  = '0;
          w_state_nxt = FILL;
        end
      end
      FILL: begin
        fsm_busy = 1'b1;
        if (r_issue_cnt < ISS_DONE) begin
          mem_req        = 1'b1;
          memory_address = r_base + w_issue_off;
          w_issue_nxt    = r_issue_cnt + ISS_W'(1);
        end
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          data_array_addr  = r_base + w_recv_off;
          data_array_wdata = memory_data;
          w_recv_nxt       = r_recv_cnt + RECV_W'(1);
          // Last word of the block: tag goes in with it.
          if (r_recv_cnt == RECV_LAST) begin
            write_tag_array = 1'b1;
            tag_array_addr  = r_base;
            w_state_nxt     = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef CACHE_FILL_PERF_EN
  logic [15:0] r_perf_miss, r_perf_stall;

  // Saturating miss and stall counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_miss  <= '0;
      r_perf_stall <= '0;
    end else begin
      if ((r_state == IDLE) && miss_detected && (r_perf_miss != 16'hFFFF))
        r_perf_miss <= r_perf_miss + 16'd1;
      if (fsm_busy && (r_perf_stall != 16'hFFFF))
        r_perf_stall <= r_perf_stall + 16'd1;
    end
  end

  assign perf_miss_cnt  = r_perf_miss;
  assign perf_stall_cnt = r_perf_stall;
`endif

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: table of fill vectors plus hand sequences for
// back-to-back misses and reset during a fill. A scoreboard holds expected
// request, data-write and tag-write addresses; a memory model returns words
// a fixed latency after each observed request.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        fsm_busy;
  logic        mem_req;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [15:0] data_array_addr;
  logic [15:0] data_array_wdata;
  logic        write_tag_array;
  logic [15:0] tag_array_addr;
`ifdef CACHE_FILL_PERF_EN
  logic [15:0] perf_miss_cnt;
  logic [15:0] perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .fsm_busy          (fsm_busy),
    .mem_req           (mem_req),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .data_array_addr   (data_array_addr),
    .data_array_wdata  (data_array_wdata),
    .write_tag_array   (write_tag_array),
    .tag_array_addr    (tag_array_addr)
`ifdef CACHE_FILL_PERF_EN
    ,
    .perf_miss_cnt     (perf_miss_cnt),
    .perf_stall_cnt    (perf_stall_cnt)
`endif
  );

  typedef struct {
    logic [15:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic [15:0] miss;
    int          lat;
    logic [15:0] base;
    int          busy;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          cur_lat = 4;
  bit          force_valid = 1'b0;
  int          busy_cnt, tag_seen, tag_cyc, first_req_cyc, writes_seen, returns_sent;
  logic [15:0] exp_req[$];
  logic [15:0] exp_wr[$];
  logic [15:0] exp_tag[$];
  pend_t       pipe[$];

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input logic [15:0] val);
    checks++;
    errors++;
    $display("FAIL %s: got address %h, none expected (cycle %0d)", name, val, cyc);
  endtask

  // One clock: observe outputs at negedge, then advance and drive memory returns.
  task automatic tick();
    pend_t       p;
    logic [15:0] a;
    @(negedge clk);
    if (fsm_busy === 1'b1) busy_cnt++;
    if (mem_req === 1'b1) begin
      if (exp_req.size() == 0) unexpected("mem_req", memory_address);
      else chk("mem_req addr", 32'(memory_address), 32'(exp_req.pop_front()));
      if (first_req_cyc < 0) first_req_cyc = cyc;
      pipe.push_back('{memory_address, cyc + cur_lat});
    end
    if (write_data_array === 1'b1) begin
      writes_seen++;
      if (exp_wr.size() == 0) unexpected("data write", data_array_addr);
      else begin
        a = exp_wr.pop_front();
        chk("data write addr", 32'(data_array_addr), 32'(a));
        chk("data write data", 32'(data_array_wdata), 32'(mem_word(a)));
      end
    end
    if (write_tag_array === 1'b1) begin
      tag_seen++;
      tag_cyc = cyc;
      if (exp_tag.size() == 0) unexpected("tag write", tag_array_addr);
      else chk("tag write addr", 32'(tag_array_addr), 32'(exp_tag.pop_front()));
    end
    @(posedge clk);
    #1;
    cyc++;
    memory_data_valid = force_valid;
    memory_data       = force_valid ? 16'hDEAD : 16'h0000;
    if (pipe.size() > 0 && pipe[0].due == cyc) begin
      p = pipe.pop_front();
      memory_data_valid = 1'b1;
      memory_data       = mem_word(p.addr);
      returns_sent++;
    end
  endtask

  task automatic push_block(input logic [15:0] base);
    for (int i = 0; i < 8; i++) begin
      exp_req.push_back(base + 16'(2 * i));
      exp_wr.push_back(base + 16'(2 * i));
    end
    exp_tag.push_back(base);
  endtask

  // Full fill; returns right after the tag-write cycle, busy cycles counted from the miss.
  task automatic run_fill(input logic [15:0] miss, input logic [15:0] base, input int lat,
                          input bit hold, output int busy);
    int n;
    cur_lat = lat;
    push_block(base);
    busy_cnt = 0;
    tag_seen = 0;
    first_req_cyc = -1;
    miss_detected = 1'b1;
    miss_address  = miss;
    tick();
    if (hold) miss_address = 16'h5550;
    else miss_detected = 1'b0;
    n = 0;
    while (tag_seen == 0 && n < 64) begin
      tick();
      n++;
    end
    if (tag_seen == 0) unexpected("fill timeout, tag write", base);
    miss_detected = 1'b0;
    chk("scoreboard drained", 32'(exp_req.size() + exp_wr.size() + exp_tag.size()), 32'd0);
    busy = busy_cnt;
  endtask

  task automatic drain_pipe();
    int n = 0;
    while (pipe.size() > 0 && n < 32) begin
      tick();
      n++;
    end
    chk("memory pipe drained", 32'(pipe.size()), 32'd0);
  endtask

  vec_t vecs[4];
  int   busy;
  int   t_a;

  initial begin
    vecs[0] = '{16'h1234, 4, 16'h1230, 13};
    vecs[1] = '{16'hFFFF, 4, 16'hFFF0, 13};
    vecs[2] = '{16'h0007, 1, 16'h0000, 10};
    vecs[3] = '{16'hABCD, 7, 16'hABC0, 16};

    rst = 1'b1;
    miss_detected = 1'b0;
    miss_address = 16'h0000;
    memory_data_valid = 1'b0;
    memory_data = 16'h0000;
    writes_seen = 0;
    returns_sent = 0;
    tag_seen = 0;

    // Reset two cycles, then idle outputs and ignored valid pulses.
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset fsm_busy", 32'(fsm_busy), 32'd0);
    chk("reset mem_req", 32'(mem_req), 32'd0);
    chk("reset memory_address", 32'(memory_address), 32'd0);
    chk("reset write_data_array", 32'(write_data_array), 32'd0);
    chk("reset write_tag_array", 32'(write_tag_array), 32'd0);
    chk("reset tag_array_addr", 32'(tag_array_addr), 32'd0);
`ifdef CACHE_FILL_PERF_EN
    chk("reset perf_miss_cnt", 32'(perf_miss_cnt), 32'd0);
    chk("reset perf_stall_cnt", 32'(perf_stall_cnt), 32'd0);
`endif
    force_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    force_valid = 1'b0;
    tick();
    chk("idle valid writes", 32'(writes_seen), 32'd0);
    chk("idle valid tags", 32'(tag_seen), 32'd0);

    // Table of fills with different addresses and latencies.
    for (int i = 0; i < 4; i++) begin
      run_fill(vecs[i].miss, vecs[i].base, vecs[i].lat, 1'b0, busy);
      chk($sformatf("vec%0d busy cycles", i), 32'(busy), 32'(vecs[i].busy));
`ifdef CACHE_FILL_PERF_EN
      if (i == 1) begin
        #1;
        chk("perf_miss_cnt", 32'(perf_miss_cnt), 32'd2);
        chk("perf_stall_cnt", 32'(perf_stall_cnt), 32'd26);
      end
`endif
      busy_cnt = 0;
      tick();
      chk($sformatf("vec%0d busy drop", i), 32'(busy_cnt), 32'd0);
      drain_pipe();
    end

    // Miss held during a fill, then a new miss in the first idle cycle.
    run_fill(16'h1234, 16'h1230, 4, 1'b1, busy);
    chk("held miss busy cycles", 32'(busy), 32'd13);
    t_a = tag_cyc;
    run_fill(16'h0040, 16'h0040, 3, 1'b0, busy);
    chk("back-to-back first request gap", 32'(first_req_cyc - t_a), 32'd2);
    chk("back-to-back busy cycles", 32'(busy), 32'd12);
    busy_cnt = 0;
    tick();
    chk("back-to-back busy drop", 32'(busy_cnt), 32'd0);
    drain_pipe();

    // Reset asserted in the cycle of the third returned word.
    cur_lat = 4;
    push_block(16'h1230);
    writes_seen = 0;
    returns_sent = 0;
    tag_seen = 0;
    miss_detected = 1'b1;
    miss_address = 16'h1234;
    tick();
    miss_detected = 1'b0;
    for (int n = 0; n < 32 && returns_sent < 3; n++) tick();
    chk("third word returned", 32'(returns_sent), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_req.delete();
    exp_wr.delete();
    exp_tag.delete();
    busy_cnt = 0;
    tick();
    chk("after reset busy", 32'(busy_cnt), 32'd0);
    drain_pipe();
    chk("after reset writes", 32'(writes_seen), 32'd3);
    chk("after reset tag writes", 32'(tag_seen), 32'd0);
    writes_seen = 0;
    run_fill(16'h1230, 16'h1230, 4, 1'b0, busy);
    chk("refill writes", 32'(writes_seen), 32'd8);
    chk("refill busy cycles", 32'(busy), 32'd13);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
